sixteen_bit_mult: RTL and testbench



---
 rtl/sixteen_bit_mult.sv | 98 +++++++++
 tb/tb_sixteen_bit_mult.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sixteen_bit_mult.sv
// sixteen_bit_mult
//   Unsigned 16x16 -> 32-bit multiplier built as a ripple array of 1-bit
//   full-adder cells, with the product registered once on the rising edge.
//
//   Ports
//     clk : system clock, all state updates on its rising edge
//     rst : asynchronous, active-high reset; clears c at once
//     a   : 16-bit unsigned multiplicand
//     b   : 16-bit unsigned multiplier
//     c   : 32-bit registered product a*b
//
//   Handshake: none. There is no valid/ready pair. A new product is
//   captured on every rising edge, so c after edge k is a*b as sampled
//   just before edge k.

// 1-bit full adder. Tie cin to 0 for half-adder behaviour.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module sixteen_bit_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] c
);

  logic [31:0] p_next;

  // Each row keeps its own sum vector and carry-out inside its generate
  // scope. Row i adds pp[i][*] = a & b[i] to the previous row's sum shifted
  // down by one bit, with the previous carry-out filling the top position.
  // The LSB of each row's sum is the finished product bit i.
  for (genvar i = 0; i < 16; i++) begin : g_row
    logic [15:0] s;
    logic        co;

    if (i == 0) begin : g_first
      assign s  = a & {16{b[0]}};
      assign co = 1'b0;
    end else begin : g_add
      for (genvar j = 0; j < 16; j++) begin : g_col
        logic pp;
        logic y_in;
        logic c_in;
        logic c_out;

        assign pp = a[j] & b[i];

        if (j < 15) begin : g_mid
          assign y_in = g_row[i-1].s[j+1];
        end else begin : g_top
          assign y_in = g_row[i-1].co;
        end

        // Each cell has its own carry net so the chain is not a single
        // self-referencing vector.
        if (j == 0) begin : g_lsb
          assign c_in = 1'b0;
        end else begin : g_chain
          assign c_in = g_row[i].g_add.g_col[j-1].c_out;
        end

        full_adder u_fa (
          .x    (pp),
          .y    (y_in),
          .cin  (c_in),
          .sum  (s[j]),
          .cout (c_out)
        );
      end
      assign co = g_add.g_col[15].c_out;
    end

    assign p_next[i] = s[0];
  end

  // The last row supplies the upper half of the product.
  assign p_next[30:16] = g_row[15].s[15:1];
  assign p_next[31]    = g_row[15].co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= 32'h0000_0000;
    end else begin
      c <= p_next;
    end
  end

endmodule

// File: tb/tb_sixteen_bit_mult.sv
module tb_sixteen_bit_mult;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] c;

  int checks;
  int errors;

  sixteen_bit_mult dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  // Clock: 10 ns period, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the edge, then check 1 ns after the next edge.
  task automatic step(input logic [15:0] va, input logic [15:0] vb,
                      input logic [31:0] exp, input string tag);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    check(tag, c, exp);
  endtask

  logic [15:0] corners [5];
  logic [15:0] ra;
  logic [15:0] rb;
  int          rand_err_before;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    a = 16'hFFFF;
    b = 16'hFFFF;

    // Reset behaviour: c cleared as soon as rst rises, held through edges.
    #1 rst = 1'b1;
    #1 check("reset_async_clear", c, 32'h0000_0000);
    @(posedge clk); #1 check("reset_hold_edge1", c, 32'h0000_0000);
    @(posedge clk); #1 check("reset_hold_edge2", c, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_low_before_edge", c, 32'h0000_0000);
    @(posedge clk); #1 check("reset_release_max", c, 32'hFFFE_0001);

    // Basic value and hold.
    step(16'h000F, 16'h000F, 32'h0000_00E1, "basic_15x15");
    @(posedge clk); #1 check("basic_hold", c, 32'h0000_00E1);

    // Identity and zero.
    step(16'h0001, 16'hABCD, 32'h0000_ABCD, "identity");
    step(16'h0000, 16'hFFFF, 32'h0000_0000, "zero");
    step(16'h8000, 16'h0002, 32'h0001_0000, "msb_shift");

    // Back-to-back operands on consecutive edges.
    step(16'h1234, 16'h5678, 32'h0626_0060, "b2b_1");
    step(16'hFFFF, 16'h0001, 32'h0000_FFFF, "b2b_2");
    step(16'h00FF, 16'h0100, 32'h0000_FF00, "b2b_3");

    // Asynchronous reset between edges, with operands changed during reset.
    step(16'hFFFF, 16'h0001, 32'h0000_FFFF, "pre_reset");
    #2 rst = 1'b1;
    #1 check("midstream_async_clear", c, 32'h0000_0000);
    a = 16'h00FF;
    b = 16'h0100;
    @(negedge clk);
    rst = 1'b0;
    #1 check("midstream_still_zero", c, 32'h0000_0000);
    @(posedge clk); #1 check("midstream_reload", c, 32'h0000_FF00);

    // Corner operand pairs (expected values computed by the bench).
    corners[0] = 16'h0000;
    corners[1] = 16'h0001;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;
    corners[4] = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        step(corners[i], corners[j], 32'(corners[i]) * 32'(corners[j]), "corner");
      end
    end

    // Hand-checked spot values.
    step(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "spot_7fff_sq");
    step(16'h8000, 16'h8000, 32'h4000_0000, "spot_8000_sq");
    step(16'hAAAA, 16'h5555, 32'h38E3_1C72, "spot_a_5");

    // Random regression against the unsigned reference product.
    rand_err_before = errors;
    for (int k = 0; k < 10000; k++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      step(ra, rb, 32'(ra) * 32'(rb), "random");
      if (errors - rand_err_before > 20) begin
        $display("FAIL random: too many errors, stopping random loop");
        break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
